// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the word-granular DMA engine.
package mem_dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WAIT,
        WR,
        DONE
    } dma_state_e;

    localparam logic DMA_MODE_COPY = 1'b0;
    localparam logic DMA_MODE_FILL = 1'b1;

    localparam logic [3:0] BE_ALL = 4'b1111;

endpackage

// File: rtl/ram32.sv
// Demo single-port 32-bit word RAM with byte enables and fixed one-cycle
// read latency. Accesses outside the implemented range are dropped (reads
// still answer, with zero data).
module ram32 #(
    parameter int unsigned DEPTH_W = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o
);

    logic [31:0]        mem [2**DEPTH_W];
    logic [DEPTH_W-1:0] idx;
    logic               hit;
    logic               unused_addr;

    always_comb begin
        idx         = addr_i[DEPTH_W+1:2];
        hit         = (addr_i[31:DEPTH_W+2] == '0);
        unused_addr = ^addr_i[1:0];
    end

    // Byte-enabled write port.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i && hit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem[idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // Read response one cycle after the request.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_o <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= req_i && !we_i;
            if (req_i && !we_i) begin
                rdata_o <= hit ? mem[idx] : '0;
            end
        end
    end

endmodule

// File: rtl/mem_dma32.sv
// Word-granular DMA initiator: block copy (read/wait/write per word) or
// constant fill (one write per cycle) on a fixed one-cycle-latency memory port.
// Outputs are decoded from state and registered datapath only.
module mem_dma32
    import mem_dma_pkg::*;
#(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [31:0]      src_i,
    input  logic [31:0]      dst_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [31:0]      pattern_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             err_o,
    output logic             req_o,
    output logic             we_o,
    output logic [3:0]       be_o,
    output logic [31:0]      addr_o,
    output logic [31:0]      wdata_o,
    input  logic             rvalid_i,
    input  logic [31:0]      rdata_i
);

    dma_state_e       state_q, state_d;
    logic             mode_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [LEN_W-1:0] cnt_q;
    logic [31:0]      buf_q;
    logic [31:0]      pat_q;
    logic             err_q;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and state-decoded memory/status outputs.
    always_comb begin
        state_d = state_q;
        req_o   = 1'b0;
        we_o    = 1'b0;
        addr_o  = '0;
        wdata_o = '0;
        busy_o  = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        state_d = DONE;
                    end else if (mode_i == DMA_MODE_FILL) begin
                        state_d = WR;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD: begin
                req_o   = 1'b1;
                addr_o  = src_q;
                busy_o  = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                busy_o  = 1'b1;
                state_d = rvalid_i ? WR : DONE;
            end
            WR: begin
                req_o   = 1'b1;
                we_o    = 1'b1;
                addr_o  = dst_q;
                wdata_o = (mode_q == DMA_MODE_FILL) ? pat_q : buf_q;
                busy_o  = 1'b1;
                if (cnt_q == LEN_W'(1)) begin
                    state_d = DONE;
                end else if (mode_q == DMA_MODE_FILL) begin
                    state_d = WR;
                end else begin
                    state_d = RD;
                end
            end
            DONE: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        be_o  = req_o ? BE_ALL : '0;
        err_o = err_q;
    end

    // Datapath: latch the job at start, capture read data, advance pointers/counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mode_q <= DMA_MODE_COPY;
            src_q  <= '0;
            dst_q  <= '0;
            cnt_q  <= '0;
            buf_q  <= '0;
            pat_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mode_q <= mode_i;
                        src_q  <= src_i & ~32'd3;
                        dst_q  <= dst_i & ~32'd3;
                        cnt_q  <= len_i;
                        pat_q  <= pattern_i;
                        err_q  <= 1'b0;
                    end
                end
                WAIT: begin
                    if (rvalid_i) begin
                        buf_q <= rdata_i;
                    end else begin
                        err_q <= 1'b1;
                    end
                end
                WR: begin
                    src_q <= src_q + 32'd4;
                    dst_q <= dst_q + 32'd4;
                    cnt_q <= cnt_q - LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
